nios2_proc_ram_arbiter: RTL and testbench

NIOS2_PROC_RAM_ARBITER -- requirements
Module: nios2_proc_ram_arbiter

---
 rtl/nios2_proc_ram_arbiter_pkg.sv | 26 ++
 rtl/nios2_proc_ram_arbiter_if.sv | 34 +++
 rtl/nios2_proc_ram_arbiter_rr_arb2.sv | 45 ++++
 rtl/nios2_proc_ram_arbiter.sv | 126 ++++++++++++
 tb/tb_nios2_proc_ram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_proc_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_proc_ram_arb_pkg
//  Description : Shared defaults, read-owner type and address range helper
//                for the dual-master processor RAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package nios2_proc_ram_arb_pkg;

   localparam int          DEF_ADDR_W    = 14;
   localparam int          DEF_DATA_W    = 32;
   localparam int unsigned DEF_RAM_WORDS = 10360;

   // Which master a pending read return belongs to
   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   // True when a word address falls inside the populated RAM
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
      return (addr < words);
   endfunction

endpackage : nios2_proc_ram_arb_pkg
`default_nettype wire

// File: rtl/nios2_proc_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_proc_ram_arbiter_if
//  Description : Avalon-MM style master bundle (request, wait, read return).
//  Revision    : 1.0  initial release
// ============================================================================
interface nios2_proc_ram_arbiter_if
   import nios2_proc_ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic                  read;
   logic                  write;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     writedata;
   logic                  waitrequest;
   logic [DATA_W-1:0]     readdata;
   logic                  readdatavalid;

   modport master (
      output read, write, address, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  read, write, address, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface : nios2_proc_ram_arbiter_if
`default_nettype wire

// File: rtl/nios2_proc_ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant. A lone requester wins at once;
//                on a conflict the master not granted last wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
   import nios2_proc_ram_arb_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       reset_n,
   input  wire logic       enable,
   input  wire logic [1:0] req,
   output logic      [1:0] grant
);

   owner_t last_grant;

   // One-hot grant, combinational so the winner sees waitrequest low this cycle
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Remember the last accepted master; reset favours m0 on the first conflict
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= OWN_M1;
      end else if (grant[0]) begin
         last_grant <= OWN_M0;
      end else if (grant[1]) begin
         last_grant <= OWN_M1;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/nios2_proc_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_proc_ram_arbiter
//  Description : Shares one single-port RAM between two Avalon-MM masters.
//                One access per cycle, 1-cycle read latency, out-of-range
//                accesses are absorbed and flagged, conflicts are counted.
//  Revision    : 1.0  initial release
// ============================================================================
module nios2_proc_ram_arbiter
   import nios2_proc_ram_arb_pkg::*;
#(
   parameter int          ADDR_W    = DEF_ADDR_W,
   parameter int          DATA_W    = DEF_DATA_W,
   parameter int unsigned RAM_WORDS = DEF_RAM_WORDS
) (
   input  wire logic                 clk,
   input  wire logic                 reset_n,
   input  wire logic                 freeze,
   nios2_proc_ram_arbiter_if.slave   m0,
   nios2_proc_ram_arbiter_if.slave   m1,
   output logic [ADDR_W-1:0]         ram_address,
   output logic [DATA_W/8-1:0]       ram_byteenable,
   output logic [DATA_W-1:0]         ram_writedata,
   output logic                      ram_chipselect,
   output logic                      ram_write,
   output logic                      ram_clken,
   input  wire logic [DATA_W-1:0]    ram_readdata,
   output logic                      oor_err,
   output logic [15:0]               conflict_cnt
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [1:0]          req;
   logic [1:0]          grant;
   logic                arb_enable;
   logic                accept;
   owner_t              sel;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_address;
   logic [DATA_W/8-1:0] sel_byteenable;
   logic [DATA_W-1:0]   sel_writedata;
   logic                in_range;
   logic [DATA_W-1:0]   ret_data;

   logic                rd_valid;
   owner_t              rd_owner;
   logic                rd_oor;

   // read+write together is a write, so either strobe is a request
   assign req        = {m1.read | m1.write, m0.read | m0.write};
   // Nothing is granted under freeze or while reset is held
   assign arb_enable = reset_n & ~freeze;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (arb_enable),
      .req     (req),
      .grant   (grant)
   );

   assign accept = |grant;
   assign sel    = grant[1] ? OWN_M1 : OWN_M0;

   // Winner's request steers the RAM port
   always_comb begin
      sel_write      = m0.write;
      sel_address    = m0.address;
      sel_byteenable = m0.byteenable;
      sel_writedata  = m0.writedata;
      if (sel == OWN_M1) begin
         sel_write      = m1.write;
         sel_address    = m1.address;
         sel_byteenable = m1.byteenable;
         sel_writedata  = m1.writedata;
      end
   end

   assign in_range       = addr_in_range(32'(sel_address), RAM_WORDS);

   assign ram_address    = sel_address;
   assign ram_byteenable = sel_byteenable;
   assign ram_writedata  = sel_writedata;
   assign ram_chipselect = accept & in_range;
   assign ram_write      = ram_chipselect & sel_write;
   assign ram_clken      = 1'b1;
   assign oor_err        = accept & ~in_range;

   assign m0.waitrequest = ~grant[0];
   assign m1.waitrequest = ~grant[1];

   // Track who owns next cycle's read return and whether it must read as zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_owner <= OWN_M0;
         rd_oor   <= 1'b0;
      end else begin
         rd_valid <= accept & ~sel_write;
         if (accept & ~sel_write) begin
            rd_owner <= sel;
            rd_oor   <= ~in_range;
         end
      end
   end

   // An out-of-range read returns zero instead of whatever the RAM drives
   assign ret_data         = rd_oor ? '0 : ram_readdata;

   assign m0.readdatavalid = rd_valid & (rd_owner == OWN_M0);
   assign m1.readdatavalid = rd_valid & (rd_owner == OWN_M1);
   assign m0.readdata      = m0.readdatavalid ? ret_data : '0;
   assign m1.readdata      = m1.readdatavalid ? ret_data : '0;

   // Saturating count of cycles in which both masters want the RAM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conflict_cnt <= 16'd0;
      end else if ((&req) && (conflict_cnt != CNT_MAX)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule : nios2_proc_ram_arbiter
`default_nettype wire

// File: tb/tb_nios2_proc_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios2_proc_ram_arbiter
//  Description : Bench for the dual-master RAM arbiter: directed scenarios
//                followed by random traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nios2_proc_ram_arbiter;
   import nios2_proc_ram_arb_pkg::*;

   localparam int AW    = 14;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int WORDS = 10360;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic freeze  = 1'b0;

   nios2_proc_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
   nios2_proc_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic [DW-1:0] ram_writedata;
   logic [DW-1:0] ram_readdata;
   logic          ram_chipselect;
   logic          ram_write;
   logic          ram_clken;
   logic          oor_err;
   logic [15:0]   conflict_cnt;

   nios2_proc_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_WORDS(WORDS)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .freeze         (freeze),
      .m0             (m0_bus),
      .m1             (m1_bus),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_writedata  (ram_writedata),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata),
      .oor_err        (oor_err),
      .conflict_cnt   (conflict_cnt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- check bookkeeping ----------------
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail(input string name);
      n_total++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ---------------- RAM device (1-cycle synchronous read) ----------------
   logic [DW-1:0] ram_mem [WORDS];
   logic [DW-1:0] ram_merge;
   always @(posedge clk) begin
      if (ram_clken) begin
         if (ram_chipselect && ram_write && (int'(ram_address) < WORDS)) begin
            ram_merge = ram_mem[ram_address];
            for (int b = 0; b < BW; b++)
               if (ram_byteenable[b]) ram_merge[8*b +: 8] = ram_writedata[8*b +: 8];
            ram_mem[ram_address] <= ram_merge;
         end
         ram_readdata <= (int'(ram_address) < WORDS) ? ram_mem[ram_address] : 32'hBAD0_BAD0;
      end
   end

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'hDEAD_BEEF;
      return 32'(i * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic        mst;
      logic [31:0] data;
      int unsigned cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem [WORDS];
   logic          m_last = 1'b1;
   logic [15:0]   m_cnt  = 16'd0;

   // Per cycle: who should win, what the RAM port must show, what returns next
   always @(negedge clk) begin : model
      logic          r0, r1, wr, inr;
      int            win;
      logic [AW-1:0] a;
      logic [BW-1:0] be;
      logic [DW-1:0] wd, merged;
      if (!reset_n) begin
         chk("rst_wait0", 32'(m0_bus.waitrequest), 1);
         chk("rst_wait1", 32'(m1_bus.waitrequest), 1);
         chk("rst_rdv0", 32'(m0_bus.readdatavalid), 0);
         chk("rst_rdv1", 32'(m1_bus.readdatavalid), 0);
         chk("rst_rdata0", m0_bus.readdata, 0);
         chk("rst_rdata1", m1_bus.readdata, 0);
         chk("rst_cs", 32'(ram_chipselect), 0);
         chk("rst_ram_write", 32'(ram_write), 0);
         chk("rst_oor", 32'(oor_err), 0);
         chk("rst_cnt", 32'(conflict_cnt), 0);
         exp_q.delete();
         m_last = 1'b1;
         m_cnt  = 16'd0;
      end else begin
         r0  = m0_bus.read | m0_bus.write;
         r1  = m1_bus.read | m1_bus.write;
         win = -1;
         if (!freeze) begin
            if (r0 && r1) win = m_last ? 0 : 1;
            else if (r0)  win = 0;
            else if (r1)  win = 1;
         end
         chk("wait0", 32'(m0_bus.waitrequest), (win == 0) ? 32'd0 : 32'd1);
         chk("wait1", 32'(m1_bus.waitrequest), (win == 1) ? 32'd0 : 32'd1);
         chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
         chk("ram_clken", 32'(ram_clken), 1);
         if (r0 && r1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (win >= 0) begin
            a   = win[0] ? m1_bus.address    : m0_bus.address;
            wr  = win[0] ? m1_bus.write      : m0_bus.write;
            be  = win[0] ? m1_bus.byteenable : m0_bus.byteenable;
            wd  = win[0] ? m1_bus.writedata  : m0_bus.writedata;
            inr = (int'(a) < WORDS);
            chk("ram_cs", 32'(ram_chipselect), 32'(inr));
            chk("ram_write", 32'(ram_write), 32'(inr && wr));
            chk("oor_err", 32'(oor_err), 32'(!inr));
            if (inr) chk("ram_address", 32'(ram_address), 32'(a));
            if (inr && wr) begin
               chk("ram_be", 32'(ram_byteenable), 32'(be));
               chk("ram_wdata", ram_writedata, wd);
               merged = ref_mem[a];
               for (int b = 0; b < BW; b++)
                  if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
               ref_mem[a] = merged;
            end
            if (!wr) exp_q.push_back('{mst: win[0], data: (inr ? ref_mem[a] : 32'd0), cyc: cyc + 1});
            m_last = win[0];
         end else begin
            chk("idle_cs", 32'(ram_chipselect), 0);
            chk("idle_ram_write", 32'(ram_write), 0);
            chk("idle_oor", 32'(oor_err), 0);
         end
      end
   end

   // Read returns are popped and compared whenever the DUT presents one
   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n) begin
         if (!m0_bus.readdatavalid) chk("nonowner_rdata0", m0_bus.readdata, 0);
         if (!m1_bus.readdatavalid) chk("nonowner_rdata1", m1_bus.readdata, 0);
         if (m0_bus.readdatavalid && m1_bus.readdatavalid) begin
            fail("dual_readdatavalid");
         end else if (m0_bus.readdatavalid || m1_bus.readdatavalid) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_readdatavalid");
            end else begin
               e = exp_q.pop_front();
               chk("rdv_owner", 32'(m1_bus.readdatavalid), 32'(e.mst));
               chk("rdata", m1_bus.readdatavalid ? m1_bus.readdata : m0_bus.readdata, e.data);
               chk("rdv_latency", cyc, e.cyc);
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            fail("missing_readdatavalid");
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit m, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
      if (!m) begin
         m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
         m0_bus.byteenable = be; m0_bus.writedata = d;
      end else begin
         m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
         m1_bus.byteenable = be; m1_bus.writedata = d;
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic rand_req(input bit m, output bit busy);
      int unsigned op, asel;
      logic [AW-1:0] a;
      op   = $urandom_range(0, 4);
      asel = $urandom_range(0, 9);
      if (asel < 6)      a = AW'($urandom_range(0, 31));
      else if (asel < 8) a = AW'($urandom_range(WORDS - 4, WORDS + 3));
      else               a = AW'($urandom_range(0, (1 << AW) - 1));
      case (op)
         2:       drive(m, 1'b1, 1'b0, a, BW'($urandom), $urandom);
         3:       drive(m, 1'b0, 1'b1, a, BW'($urandom), $urandom);
         4:       drive(m, 1'b1, 1'b1, a, BW'($urandom), $urandom);
         default: drive(m, 1'b0, 1'b0, '0, '0, '0);
      endcase
      busy = (op >= 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] exp_word;
      bit          pend [2];
      for (int i = 0; i < WORDS; i++) begin
         ram_mem[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end
      idle();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Round-robin on sustained conflict right after reset: m0,m1,m0,m1
      drive(1'b0, 1'b1, 1'b0, 14'd1, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 14'd2, '0, '0);
      @(negedge clk); chk("rr1_m0_wait", 32'(m0_bus.waitrequest), 0);
      chk("rr1_m1_wait", 32'(m1_bus.waitrequest), 1);
      step(); drive(1'b0, 1'b1, 1'b0, 14'd3, '0, '0);
      @(negedge clk); chk("rr2_m1_wait", 32'(m1_bus.waitrequest), 0);
      chk("rr2_m0_wait", 32'(m0_bus.waitrequest), 1);
      step(); drive(1'b1, 1'b1, 1'b0, 14'd4, '0, '0);
      @(negedge clk); chk("rr3_m0_wait", 32'(m0_bus.waitrequest), 0);
      step(); drive(1'b0, 1'b1, 1'b0, 14'd6, '0, '0);
      @(negedge clk); chk("rr4_m1_wait", 32'(m1_bus.waitrequest), 0);
      step(); drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk); chk("rr_conflict_cnt", 32'(conflict_cnt), 4);
      step(); idle();

      // Lone read of word 5
      step(); drive(1'b0, 1'b1, 1'b0, 14'd5, '0, '0);
      @(negedge clk); chk("rd5_wait", 32'(m0_bus.waitrequest), 0);
      step(); idle();
      @(negedge clk); chk("rd5_rdv", 32'(m0_bus.readdatavalid), 1);
      chk("rd5_data", m0_bus.readdata, 32'hDEAD_BEEF);

      // Partial write by m1 then read-back by m0
      step(); drive(1'b1, 1'b0, 1'b1, 14'd100, 4'b0011, 32'h1234_5678);
      @(negedge clk); chk("wr100_wait", 32'(m1_bus.waitrequest), 0);
      step(); idle(); drive(1'b0, 1'b1, 1'b0, 14'd100, '0, '0);
      @(negedge clk); chk("rd100_wait", 32'(m0_bus.waitrequest), 0);
      step(); idle();
      exp_word = init_word(100);
      exp_word[15:0] = 16'h5678;
      @(negedge clk); chk("rd100_rdv", 32'(m0_bus.readdatavalid), 1);
      chk("rd100_data", m0_bus.readdata, exp_word);

      // First out-of-range word
      step(); drive(1'b0, 1'b1, 1'b0, 14'd10360, '0, '0);
      @(negedge clk); chk("oor_cs", 32'(ram_chipselect), 0);
      chk("oor_pulse", 32'(oor_err), 1);
      step(); idle();
      @(negedge clk); chk("oor_rdv", 32'(m0_bus.readdatavalid), 1);
      chk("oor_data", m0_bus.readdata, 0);

      // Reset pulse with a read in flight
      step(); drive(1'b0, 1'b1, 1'b0, 14'd7, '0, '0);
      @(negedge clk); chk("rst_rd_wait", 32'(m0_bus.waitrequest), 0);
      @(posedge clk); #1 reset_n = 1'b0; idle();
      @(posedge clk); #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("post_rst_rdv0", 32'(m0_bus.readdatavalid), 0);
         step();
      end
      chk("post_rst_cnt", 32'(conflict_cnt), 0);
      drive(1'b0, 1'b1, 1'b0, 14'd8, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 14'd9, '0, '0);
      @(negedge clk); chk("post_rst_m0_wins", 32'(m0_bus.waitrequest), 0);
      step(); drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk); chk("post_rst_m1_next", 32'(m1_bus.waitrequest), 0);
      step(); idle();
      step();

      // Random traffic, holding each request until it is accepted
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         for (int m = 0; m < 2; m++)
            if (!pend[m]) rand_req(m[0], pend[m]);
         freeze = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         if (pend[0] && !m0_bus.waitrequest) pend[0] = 1'b0;
         if (pend[1] && !m1_bus.waitrequest) pend[1] = 1'b0;
         step();
      end
      idle();
      freeze = 1'b0;
      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_nios2_proc_ram_arbiter
`default_nettype wire
